// File: rtl/bellman_relax.sv
// rtl/bellman_relax.sv - Bellman-Ford relaxation engine; optional early exit via RELAX_EARLY_EXIT_EN
`timescale 1ns/1ps
module bellman_relax #(
  parameter int NODES = 32,
  parameter int PW    = 5,
  parameter int WW    = 32,
  parameter int VW    = 1 + PW + WW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          relax_start,
  input  logic [PW-1:0] src_vert,
  output logic [PW-1:0] adjmat_row_addr,
  output logic [PW-1:0] adjmat_col_addr,
  input  logic [WW-1:0] adjmat_q,
  output logic [PW-1:0] vertmat_addr_a,
  output logic [PW-1:0] vertmat_addr_b,
  input  logic [VW-1:0] vertmat_q_a,
  input  logic [VW-1:0] vertmat_q_b,
  output logic          vertmat_we,
  output logic [PW-1:0] vertmat_wr_addr,
  output logic [VW-1:0] vertmat_d,
  output logic          relax_busy,
  output logic          relax_done,
  output logic [PW-1:0] pass_count,
  output logic [15:0]   update_count
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ADDR, S_CMP, S_DONE} state_t;

  localparam logic [PW-1:0] LAST      = PW'(NODES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(NODES - 2);
  localparam logic [WW-1:0] W_INF     = {1'b0, {(WW-1){1'b1}}};
  localparam logic [WW-1:0] W_MIN     = {1'b1, {(WW-1){1'b0}}};

  state_t        state, state_nxt;
  logic [PW-1:0] src, v, i, j, pass;
  logic [15:0]   upd;
  logic          armed, dirty;

  logic                 start_ok, row_end, last_edge, relax_hit, relax;
  logic signed [WW:0]   sum_wide;
  logic signed [WW-1:0] sum, w_a, w_b;
  logic                 unused_bits;

  // armed blocks a start pulse coinciding with the first edge after reset release
  assign start_ok  = relax_start && armed;
  assign row_end   = (j == LAST);
  assign last_edge = row_end && (i == LAST);

  assign w_a      = vertmat_q_a[WW-1:0];
  assign w_b      = vertmat_q_b[WW-1:0];
  assign sum_wide = {w_a[WW-1], w_a} + {adjmat_q[WW-1], adjmat_q};

  always_comb begin
    sum = sum_wide[WW-1:0];
    if (sum_wide[WW] != sum_wide[WW-1])
      sum = sum_wide[WW] ? W_MIN : W_INF;
  end

  assign relax_hit = (adjmat_q != '0) && (i != j) && vertmat_q_a[VW-1] && (sum < w_b);
  assign relax     = (state == S_CMP) && relax_hit;

  assign unused_bits = ^{vertmat_q_a[VW-2:WW], vertmat_q_b[VW-1:WW]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start_ok) state_nxt = S_INIT;
      S_INIT: if (v == LAST) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_CMP;
      S_CMP: begin
        state_nxt = S_ADDR;
        if (last_edge) begin
          if (pass == PASS_LAST) state_nxt = S_DONE;
`ifdef RELAX_EARLY_EXIT_EN
          else if (!(dirty || relax)) state_nxt = S_DONE;
`endif
        end
      end
      S_DONE: if (start_ok) state_nxt = S_INIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
      src   <= '0;
      v     <= '0;
      i     <= '0;
      j     <= '0;
      pass  <= '0;
      upd   <= '0;
      dirty <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            src   <= src_vert;
            v     <= '0;
            i     <= '0;
            j     <= '0;
            pass  <= '0;
            upd   <= '0;
            dirty <= 1'b0;
          end
        end
        S_INIT: v <= v + 1'b1;
        S_CMP: begin
          if (relax) begin
            dirty <= 1'b1;
            if (upd != 16'hFFFF) upd <= upd + 16'd1;
          end
          j <= row_end ? '0 : j + 1'b1;
          if (row_end) i <= (i == LAST) ? '0 : i + 1'b1;
          if (last_edge) begin
            pass  <= pass + 1'b1;
            dirty <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign adjmat_row_addr = i;
  assign adjmat_col_addr = j;
  assign vertmat_addr_a  = i;
  assign vertmat_addr_b  = j;
  assign pass_count      = pass;
  assign update_count    = upd;

  // write strobe is combinational so an async reset drops it immediately
  always_comb begin
    vertmat_we      = 1'b0;
    vertmat_wr_addr = '0;
    vertmat_d       = '0;
    relax_busy      = 1'b0;
    relax_done      = 1'b0;
    unique case (state)
      S_INIT: begin
        relax_busy      = 1'b1;
        vertmat_we      = 1'b1;
        vertmat_wr_addr = v;
        vertmat_d       = (v == src) ? {1'b1, src, {WW{1'b0}}} : {1'b0, v, W_INF};
      end
      S_ADDR: relax_busy = 1'b1;
      S_CMP: begin
        relax_busy = 1'b1;
        if (relax_hit) begin
          vertmat_we      = 1'b1;
          vertmat_wr_addr = j;
          vertmat_d       = {1'b1, i, sum};
        end
      end
      S_DONE: relax_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bellman_relax.sv
// tb/tb_bellman_relax.sv - table-driven bench for bellman_relax with NODES=4 memory models
`timescale 1ns/1ps
module tb_bellman_relax;

  localparam int NODES = 4;
  localparam int PW    = 5;
  localparam int WW    = 32;
  localparam int VW    = 38;
  localparam logic [31:0] INF  = 32'h7FFF_FFFF;
  localparam logic [31:0] WMIN = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          relax_start = 1'b0;
  logic [PW-1:0] src_vert = '0;
  logic [PW-1:0] adjmat_row_addr, adjmat_col_addr;
  logic [WW-1:0] adjmat_q;
  logic [PW-1:0] vertmat_addr_a, vertmat_addr_b;
  logic [VW-1:0] vertmat_q_a, vertmat_q_b;
  logic          vertmat_we;
  logic [PW-1:0] vertmat_wr_addr;
  logic [VW-1:0] vertmat_d;
  logic          relax_busy, relax_done;
  logic [PW-1:0] pass_count;
  logic [15:0]   update_count;

  bellman_relax #(.NODES(NODES), .PW(PW), .WW(WW), .VW(VW)) dut (
    .clk(clk), .reset_n(reset_n), .relax_start(relax_start), .src_vert(src_vert),
    .adjmat_row_addr(adjmat_row_addr), .adjmat_col_addr(adjmat_col_addr), .adjmat_q(adjmat_q),
    .vertmat_addr_a(vertmat_addr_a), .vertmat_addr_b(vertmat_addr_b),
    .vertmat_q_a(vertmat_q_a), .vertmat_q_b(vertmat_q_b),
    .vertmat_we(vertmat_we), .vertmat_wr_addr(vertmat_wr_addr), .vertmat_d(vertmat_d),
    .relax_busy(relax_busy), .relax_done(relax_done),
    .pass_count(pass_count), .update_count(update_count)
  );

  always #5 clk = ~clk;

  logic [31:0] adj [16];
  logic [37:0] mem [4];

  always @(posedge clk) begin
    adjmat_q    <= adj[{adjmat_row_addr[1:0], adjmat_col_addr[1:0]}];
    vertmat_q_a <= mem[vertmat_addr_a[1:0]];
    vertmat_q_b <= mem[vertmat_addr_b[1:0]];
    if (vertmat_we) mem[vertmat_wr_addr[1:0]] <= vertmat_d;
  end

  typedef struct {
    logic [4:0]        src;
    logic [15:0][31:0] adj;
    logic [3:0][37:0]  vm;
    logic [15:0]       upd;
    logic [4:0]        pass_full;
    int                done_full;
    logic [4:0]        pass_ee;
    int                done_ee;
  } vec_t;

  vec_t t [4];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt;
  logic          iw_we [4];
  logic [PW-1:0] iw_a  [4];
  logic [VW-1:0] iw_d  [4];

  function automatic logic [37:0] vw(logic r, logic [4:0] p, logic [31:0] w);
    return {r, p, w};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    // no edges, src 0
    t[0].src = 5'd0; t[0].adj = '0;
    t[0].vm[0] = vw(1, 0, 0);  t[0].vm[1] = vw(0, 1, INF);
    t[0].vm[2] = vw(0, 2, INF); t[0].vm[3] = vw(0, 3, INF);
    t[0].upd = 16'd0; t[0].pass_full = 5'd3; t[0].done_full = 100; t[0].pass_ee = 5'd1; t[0].done_ee = 36;
    // 0->1=5, 1->2=-2, 0->2=4
    t[1].src = 5'd0; t[1].adj = '0;
    t[1].adj[1] = 32'd5; t[1].adj[6] = -32'sd2; t[1].adj[2] = 32'd4;
    t[1].vm[0] = vw(1, 0, 0); t[1].vm[1] = vw(1, 0, 32'd5);
    t[1].vm[2] = vw(1, 1, 32'd3); t[1].vm[3] = vw(0, 3, INF);
    t[1].upd = 16'd3; t[1].pass_full = 5'd3; t[1].done_full = 100; t[1].pass_ee = 5'd2; t[1].done_ee = 68;
    // 0->1=-2^31+1, 1->0=-7 saturate; 2->3=-5 from unreached 2
    t[2].src = 5'd0; t[2].adj = '0;
    t[2].adj[1] = 32'h8000_0001; t[2].adj[4] = -32'sd7; t[2].adj[11] = -32'sd5;
    t[2].vm[0] = vw(1, 1, WMIN); t[2].vm[1] = vw(1, 0, WMIN);
    t[2].vm[2] = vw(0, 2, INF);  t[2].vm[3] = vw(0, 3, INF);
    t[2].upd = 16'd3; t[2].pass_full = 5'd3; t[2].done_full = 100; t[2].pass_ee = 5'd3; t[2].done_ee = 100;
    // negative cycle 0->1=1, 1->2=1, 2->0=-5
    t[3].src = 5'd0; t[3].adj = '0;
    t[3].adj[1] = 32'd1; t[3].adj[6] = 32'd1; t[3].adj[8] = -32'sd5;
    t[3].vm[0] = vw(1, 2, -32'sd9); t[3].vm[1] = vw(1, 0, -32'sd5);
    t[3].vm[2] = vw(1, 1, -32'sd4); t[3].vm[3] = vw(0, 3, INF);
    t[3].upd = 16'd9; t[3].pass_full = 5'd3; t[3].done_full = 100; t[3].pass_ee = 5'd3; t[3].done_ee = 100;

    for (int e = 0; e < 16; e++) adj[e] = 32'd0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {relax_busy, relax_done, pass_count, update_count, vertmat_we, vertmat_wr_addr, vertmat_d}, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset mid-CMP with a relax pending
    for (int e = 0; e < 16; e++) adj[e] = t[1].adj[e];
    relax_start = 1'b1; src_vert = 5'd0;
    @(negedge clk); relax_start = 1'b0;
    cnt = 0;
    while (!(vertmat_we && cnt > NODES) && cnt < 50) begin
      @(negedge clk); cnt++;
    end
    check("first_relax_seen", {63'd0, vertmat_we}, 64'd1);
    check("first_relax_edge", 64'(cnt), 64'd7);
    #2 reset_n = 1'b0;
    #1 check("we_async_drop", {63'd0, vertmat_we}, 64'd0);
    check("reset_all_zero", {relax_busy, relax_done, pass_count, update_count, adjmat_row_addr, adjmat_col_addr, vertmat_wr_addr, vertmat_d}, '0);
    @(negedge clk);
    reset_n = 1'b1; relax_start = 1'b1;
    @(negedge clk); relax_start = 1'b0;
    check("start_at_release_ignored", {relax_busy, relax_done}, 64'd0);
    @(negedge clk);
    check("idle_after_release", {relax_busy, relax_done, vertmat_we}, 64'd0);

    for (int k = 0; k < 4; k++) begin
      for (int e = 0; e < 16; e++) adj[e] = t[k].adj[e];
      relax_start = 1'b1; src_vert = t[k].src;
      @(negedge clk); relax_start = 1'b0;
      cnt = 0;
      while (!relax_done && cnt < 400) begin
        if (cnt < 4) begin
          iw_we[cnt] = vertmat_we; iw_a[cnt] = vertmat_wr_addr; iw_d[cnt] = vertmat_d;
        end
        if (cnt == 50) check($sformatf("busy_mid_run_%0d", k), {63'd0, relax_busy}, 64'd1);
        // a start pulse with another source while busy must change nothing
        if (k == 1 && cnt == 20) begin relax_start = 1'b1; src_vert = 5'd2; end
        else relax_start = 1'b0;
        @(negedge clk); cnt++;
      end
      relax_start = 1'b0;
      if (k == 0) begin
        for (int c = 0; c < 4; c++)
          check($sformatf("init_write_%0d", c), {iw_we[c], iw_a[c], iw_d[c]},
                {1'b1, 5'(c), vw(c == 0, 5'(c), (c == 0) ? 32'd0 : INF)});
      end
`ifdef RELAX_EARLY_EXIT_EN
      check($sformatf("done_edge_%0d", k), 64'(cnt), 64'(t[k].done_ee));
      check($sformatf("pass_count_%0d", k), 64'(pass_count), 64'(t[k].pass_ee));
`else
      check($sformatf("done_edge_%0d", k), 64'(cnt), 64'(t[k].done_full));
      check($sformatf("pass_count_%0d", k), 64'(pass_count), 64'(t[k].pass_full));
`endif
      check($sformatf("update_count_%0d", k), 64'(update_count), 64'(t[k].upd));
      for (int w = 0; w < 4; w++)
        check($sformatf("vertmat_%0d_%0d", k, w), 64'(mem[w]), 64'(t[k].vm[w]));
      @(negedge clk);
      check($sformatf("done_holds_%0d", k), {relax_done, relax_busy}, 64'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
